// File: rtl/avr_seq_ctrl_if.sv
// rtl/avr_seq_ctrl_if.sv - data-memory handshake bundle between the AVR sequencer and the memory port
interface avr_seq_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [4:0]  mem_rd;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_rd,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_rd,
        output mem_ack
    );
endinterface

// File: rtl/avr_seq_ctrl.sv
// rtl/avr_seq_ctrl.sv - AVR instruction sequencer: PC source, two-word JMP/LDS/STS, data-memory handshake
// Optional MEM-wait timeout with sticky mem_err is built when AVR_SEQ_MEM_TIMEOUT_EN is defined.
module avr_seq_ctrl (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [15:0]           instr,
    input  logic                  stall_req,
    avr_seq_ctrl_if.master        mem,
    output logic [2:0]            pc_select,
    output logic [15:0]           pc_jmp,
    output logic                  reg_we,
    output logic                  busy,
    output logic                  mem_err
);

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_EXEC  = 3'd1,
        ST_OPND  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        K_NONE = 2'd0,
        K_JMP  = 2'd1,
        K_LDS  = 2'd2,
        K_STS  = 2'd3
    } kind_t;

    localparam logic [2:0] PC_ZERO = 3'b000;
    localparam logic [2:0] PC_HOLD = 3'b001;
    localparam logic [2:0] PC_INC  = 3'b010;
    localparam logic [2:0] PC_REL  = 3'b100;
    localparam logic [2:0] PC_ABS  = 3'b101;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [4:0]  mem_rd_q, mem_rd_d;

    logic is_rjmp, is_jmp, is_lds, is_sts;

    assign is_rjmp = (instr[15:12] == 4'hC);
    assign is_jmp  = (instr[15:9] == 7'b1001010) && (instr[3:1] == 3'b110);
    assign is_lds  = (instr[15:9] == 7'b1001000) && (instr[3:0] == 4'h0);
    assign is_sts  = (instr[15:9] == 7'b1001001) && (instr[3:0] == 4'h0);

`ifdef AVR_SEQ_MEM_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       mem_err_q, mem_err_d;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_RESET;
            kind_q     <= K_NONE;
            mem_addr_q <= 16'h0000;
            mem_rd_q   <= 5'd0;
`ifdef AVR_SEQ_MEM_TIMEOUT_EN
            tmo_cnt_q  <= 8'd0;
            mem_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
`ifdef AVR_SEQ_MEM_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            mem_err_q  <= mem_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = mem_rd_q;
        pc_select   = PC_ZERO;
        pc_jmp      = 16'h0000;
        reg_we      = 1'b0;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
`ifdef AVR_SEQ_MEM_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        mem_err_d   = mem_err_q;
`endif

        case (state_q)
            ST_RESET: begin
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                // A pending halt wins over whatever the fetch unit is presenting.
                if (stall_req) begin
                    pc_select = PC_HOLD;
                    state_d   = ST_HALT;
                end else if (is_rjmp) begin
                    pc_select = PC_REL;
                    pc_jmp    = {{4{instr[11]}}, instr[11:0]};
                end else if (is_jmp) begin
                    pc_select = PC_INC;
                    kind_d    = K_JMP;
                    state_d   = ST_OPND;
                end else if (is_lds || is_sts) begin
                    pc_select = PC_INC;
                    kind_d    = is_lds ? K_LDS : K_STS;
                    mem_rd_d  = instr[8:4];
                    state_d   = ST_OPND;
                end else if (instr == 16'h0000) begin
                    pc_select = PC_INC;
                end else begin
                    pc_select = PC_INC;
                    reg_we    = 1'b1;
                end
            end

            ST_OPND: begin
                if (kind_q == K_JMP) begin
                    pc_select = PC_ABS;
                    pc_jmp    = instr;
                    state_d   = ST_EXEC;
                end else if (kind_q == K_LDS || kind_q == K_STS) begin
                    pc_select  = PC_HOLD;
                    mem_addr_d = instr;
                    state_d    = ST_MEM;
`ifdef AVR_SEQ_MEM_TIMEOUT_EN
                    tmo_cnt_d  = 8'd0;
`endif
                end else begin
                    pc_select = PC_INC;
                    state_d   = ST_EXEC;
                end
            end

            ST_MEM: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = (kind_q == K_STS);
                if (mem.mem_ack) begin
                    pc_select = PC_INC;
                    reg_we    = (kind_q == K_LDS);
                    state_d   = ST_EXEC;
`ifdef AVR_SEQ_MEM_TIMEOUT_EN
                end else if (tmo_cnt_q == 8'd255) begin
                    pc_select = PC_INC;
                    mem_err_d = 1'b1;
                    state_d   = ST_EXEC;
                end else begin
                    pc_select = PC_HOLD;
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`else
                end else begin
                    pc_select = PC_HOLD;
                end
`endif
            end

            ST_HALT: begin
                pc_select = PC_HOLD;
                if (!stall_req) begin
                    state_d = ST_EXEC;
                end
            end

            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_rd   = mem_rd_q;
    assign busy         = (state_q != ST_EXEC);

`ifdef AVR_SEQ_MEM_TIMEOUT_EN
    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_avr_seq_ctrl.sv
// tb/tb_avr_seq_ctrl.sv - directed self-checking bench for avr_seq_ctrl
module tb_avr_seq_ctrl;
    logic        CLK;
    logic        RST;
    logic [15:0] instr;
    logic        stall_req;
    logic [2:0]  pc_select;
    logic [15:0] pc_jmp;
    logic        reg_we;
    logic        busy;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    avr_seq_ctrl_if mif();

    avr_seq_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .instr     (instr),
        .stall_req (stall_req),
        .mem       (mif.master),
        .pc_select (pc_select),
        .pc_jmp    (pc_jmp),
        .reg_we    (reg_we),
        .busy      (busy),
        .mem_err   (mem_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        RST = 1'b1; instr = 16'h0000; stall_req = 1'b0; mif.mem_ack = 1'b0;
        @(negedge CLK); #1;
        checks++; if (pc_select !== 3'b000) begin errors++; $display("FAIL reset_pc_select: got %b expected 000", pc_select); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        checks++; if (reg_we !== 1'b0 || mif.mem_req !== 1'b0 || mif.mem_we !== 1'b0) begin errors++; $display("FAIL reset_strobes: got we=%b req=%b mwe=%b expected 0 0 0", reg_we, mif.mem_req, mif.mem_we); end
        checks++; if (pc_jmp !== 16'h0000 || mem_err !== 1'b0) begin errors++; $display("FAIL reset_jmp_err: got %h %b expected 0000 0", pc_jmp, mem_err); end
        checks++; if (mif.mem_addr !== 16'h0000 || mif.mem_rd !== 5'd0) begin errors++; $display("FAIL reset_latches: got %h %0d expected 0000 0", mif.mem_addr, mif.mem_rd); end
        @(negedge CLK); RST = 1'b0; #1;
        checks++; if (pc_select !== 3'b000 || busy !== 1'b1) begin errors++; $display("FAIL reset_first_cycle: got pc=%b busy=%b expected 000 1", pc_select, busy); end
        @(negedge CLK); #1;
        checks++; if (busy !== 1'b0 || pc_select !== 3'b010 || reg_we !== 1'b0) begin errors++; $display("FAIL reset_exit_exec: got busy=%b pc=%b we=%b expected 0 010 0", busy, pc_select, reg_we); end
    endtask

    task automatic test_exec_decode();
        @(negedge CLK); instr = 16'hCFFF; #1;
        checks++; if (pc_select !== 3'b100 || pc_jmp !== 16'hFFFF || reg_we !== 1'b0) begin errors++; $display("FAIL rjmp_neg: got pc=%b jmp=%h we=%b expected 100 ffff 0", pc_select, pc_jmp, reg_we); end
        @(negedge CLK); instr = 16'hC7FF; #1;
        checks++; if (pc_select !== 3'b100 || pc_jmp !== 16'h07FF) begin errors++; $display("FAIL rjmp_pos: got pc=%b jmp=%h expected 100 07ff", pc_select, pc_jmp); end
        @(negedge CLK); instr = 16'h0C01; mif.mem_ack = 1'b1; #1;
        checks++; if (pc_select !== 3'b010 || reg_we !== 1'b1 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL alu_op: got pc=%b we=%b req=%b expected 010 1 0", pc_select, reg_we, mif.mem_req); end
        @(negedge CLK); instr = 16'h0000; #1;
        checks++; if (pc_select !== 3'b010 || reg_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL nop_ack_ignored: got pc=%b we=%b busy=%b expected 010 0 0", pc_select, reg_we, busy); end
        mif.mem_ack = 1'b0;
    endtask

    task automatic test_jmp();
        @(negedge CLK); instr = 16'h940C; #1;
        checks++; if (pc_select !== 3'b010 || reg_we !== 1'b0) begin errors++; $display("FAIL jmp_word1: got pc=%b we=%b expected 010 0", pc_select, reg_we); end
        @(negedge CLK); instr = 16'h1234; stall_req = 1'b1; #1;
        checks++; if (pc_select !== 3'b101 || pc_jmp !== 16'h1234 || busy !== 1'b1) begin errors++; $display("FAIL jmp_word2: got pc=%b jmp=%h busy=%b expected 101 1234 1", pc_select, pc_jmp, busy); end
        @(negedge CLK); instr = 16'h0C01; #1;
        checks++; if (pc_select !== 3'b001 || reg_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_after_opnd: got pc=%b we=%b busy=%b expected 001 0 0", pc_select, reg_we, busy); end
    endtask

    task automatic test_halt();
        @(negedge CLK); #1;
        checks++; if (busy !== 1'b1 || pc_select !== 3'b001 || reg_we !== 1'b0) begin errors++; $display("FAIL halt_hold: got busy=%b pc=%b we=%b expected 1 001 0", busy, pc_select, reg_we); end
        @(negedge CLK); stall_req = 1'b0; #1;
        checks++; if (busy !== 1'b1 || pc_select !== 3'b001 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL halt_release_cycle: got busy=%b pc=%b req=%b expected 1 001 0", busy, pc_select, mif.mem_req); end
        @(negedge CLK); instr = 16'h0000; #1;
        checks++; if (busy !== 1'b0 || pc_select !== 3'b010) begin errors++; $display("FAIL halt_exit: got busy=%b pc=%b expected 0 010", busy, pc_select); end
    endtask

    task automatic test_lds();
        int req_cycles;
        req_cycles = 0;
        @(negedge CLK); instr = 16'h9150; #1;
        checks++; if (pc_select !== 3'b010 || reg_we !== 1'b0) begin errors++; $display("FAIL lds_word1: got pc=%b we=%b expected 010 0", pc_select, reg_we); end
        @(negedge CLK); instr = 16'h0200; #1;
        checks++; if (pc_select !== 3'b001 || mif.mem_req !== 1'b0 || mif.mem_rd !== 5'd21) begin errors++; $display("FAIL lds_opnd: got pc=%b req=%b rd=%0d expected 001 0 21", pc_select, mif.mem_req, mif.mem_rd); end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); instr = 16'h0000; #1;
            if (mif.mem_req === 1'b1) req_cycles++;
            checks++; if (mif.mem_we !== 1'b0 || mif.mem_addr !== 16'h0200 || pc_select !== 3'b001 || reg_we !== 1'b0) begin errors++; $display("FAIL lds_wait%0d: got we=%b addr=%h pc=%b rwe=%b expected 0 0200 001 0", i, mif.mem_we, mif.mem_addr, pc_select, reg_we); end
        end
        @(negedge CLK); mif.mem_ack = 1'b1; #1;
        if (mif.mem_req === 1'b1) req_cycles++;
        checks++; if (reg_we !== 1'b1 || pc_select !== 3'b010) begin errors++; $display("FAIL lds_ack: got we=%b pc=%b expected 1 010", reg_we, pc_select); end
        @(negedge CLK); mif.mem_ack = 1'b0; #1;
        if (mif.mem_req === 1'b1) req_cycles++;
        checks++; if (req_cycles != 4) begin errors++; $display("FAIL lds_req_len: got %0d expected 4", req_cycles); end
        checks++; if (busy !== 1'b0 || reg_we !== 1'b0 || mif.mem_addr !== 16'h0200 || mif.mem_rd !== 5'd21) begin errors++; $display("FAIL lds_after: got busy=%b we=%b addr=%h rd=%0d expected 0 0 0200 21", busy, reg_we, mif.mem_addr, mif.mem_rd); end
    endtask

    task automatic test_sts_reset();
        int we_seen;
        we_seen = 0;
        @(negedge CLK); instr = 16'h9300; #1;
        if (reg_we === 1'b1) we_seen++;
        @(negedge CLK); instr = 16'h0100; #1;
        if (reg_we === 1'b1) we_seen++;
        @(negedge CLK); instr = 16'h0000; #1;
        if (reg_we === 1'b1) we_seen++;
        checks++; if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1 || mif.mem_addr !== 16'h0100) begin errors++; $display("FAIL sts_mem: got req=%b we=%b addr=%h expected 1 1 0100", mif.mem_req, mif.mem_we, mif.mem_addr); end
        @(negedge CLK); RST = 1'b1; #1;
        if (reg_we === 1'b1) we_seen++;
        @(negedge CLK); RST = 1'b0; #1;
        if (reg_we === 1'b1) we_seen++;
        checks++; if (mif.mem_req !== 1'b0 || pc_select !== 3'b000 || mif.mem_addr !== 16'h0000) begin errors++; $display("FAIL sts_reset_abandon: got req=%b pc=%b addr=%h expected 0 000 0000", mif.mem_req, pc_select, mif.mem_addr); end
        @(negedge CLK); #1;
        checks++; if (we_seen != 0 || busy !== 1'b0) begin errors++; $display("FAIL sts_reset_no_write: got writes=%0d busy=%b expected 0 0", we_seen, busy); end
    endtask

    task automatic test_mem_wait();
        int n;
        @(negedge CLK); instr = 16'h9150; #1;
        @(negedge CLK); instr = 16'h0300; #1;
`ifdef AVR_SEQ_MEM_TIMEOUT_EN
        n = 0;
        @(negedge CLK); instr = 16'h0000; #1;
        while (pc_select !== 3'b010 && n < 300) begin
            n++;
            @(negedge CLK); #1;
        end
        checks++; if (n < 250 || n > 260 || reg_we !== 1'b0 || mif.mem_req !== 1'b1) begin errors++; $display("FAIL timeout_exit: got waits=%0d we=%b req=%b expected ~255 0 1", n, reg_we, mif.mem_req); end
        @(negedge CLK); #1;
        checks++; if (mem_err !== 1'b1 || busy !== 1'b0 || pc_select !== 3'b010) begin errors++; $display("FAIL timeout_err: got err=%b busy=%b pc=%b expected 1 0 010", mem_err, busy, pc_select); end
`else
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK); instr = 16'h0000; #1;
            if (mif.mem_req === 1'b1 && busy === 1'b1 && mem_err === 1'b0) n++;
        end
        checks++; if (n != 300) begin errors++; $display("FAIL mem_wait_forever: got %0d held cycles expected 300", n); end
        @(negedge CLK); mif.mem_ack = 1'b1; #1;
        checks++; if (reg_we !== 1'b1 || mem_err !== 1'b0) begin errors++; $display("FAIL mem_wait_ack: got we=%b err=%b expected 1 0", reg_we, mem_err); end
        @(negedge CLK); mif.mem_ack = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mem_wait_exit: got busy=%b expected 0", busy); end
`endif
    endtask

    initial begin
        test_reset();
        test_exec_decode();
        test_jmp();
        test_halt();
        test_lds();
        test_sts_reset();
        test_mem_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/avr_seq_ctrl.md
AVR_SEQ_CTRL -- requirements
Module: avr_seq_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1 bit: clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port instr, input, 16 bits: instruction word currently held by the fetch unit (opcode, or the operand word of a two-word instruction).
REQ-004 SHALL have port stall_req, input, 1 bit: external halt request (debug).
REQ-005 SHALL have port mem_ack, input, 1 bit: data-memory transfer complete.
REQ-006 SHALL have port pc_select, output, 3 bits: PC source. 000 zero, 001 hold, 010 +1, 100 relative, 101 absolute.
REQ-007 SHALL have port pc_jmp, output, 16 bits: jump offset or target.
REQ-008 SHALL have port reg_we, output, 1 bit: register-file write enable.
REQ-009 SHALL have port mem_req, output, 1 bit: data-memory request.
REQ-010 SHALL have port mem_we, output, 1 bit: 1 = store, 0 = load; valid while mem_req is high.
REQ-011 SHALL have port mem_addr, output, 16 bits: data address.
REQ-012 SHALL have port mem_rd, output, 5 bits: latched Rd index for LDS/STS.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not EXEC.
REQ-014 SHALL have port mem_err, output, 1 bit: sticky timeout flag (see Configuration).

Function
REQ-015 SHALL implement registered states RESET, EXEC, OPND, MEM and HALT; outputs are decoded combinationally from state, instr and the latched registers.
REQ-016 In RESET: pc_select=000, reg_we=0, mem_req=0; next state is EXEC unconditionally.
REQ-017 In EXEC with stall_req=1: pc_select=001, reg_we=0, go to HALT; stall_req takes priority over decode.
REQ-018 In EXEC, RJMP (1100 kkkk kkkk kkkk): pc_select=100, pc_jmp = the 12-bit K sign-extended to 16 bits, reg_we=0.
REQ-019 In EXEC, JMP (1001 010x xxxx 110x): pc_select=010, reg_we=0, latch kind=JMP, go to OPND.
REQ-020 In EXEC, LDS (1001 000d dddd 0000) or STS (1001 001d dddd 0000): pc_select=010, reg_we=0, latch kind and mem_rd=instr[8:4], go to OPND.
REQ-021 In EXEC, NOP (0x0000): pc_select=010, reg_we=0.
REQ-022 In EXEC, all other instructions: pc_select=010, reg_we=1.
REQ-023 In OPND with kind=JMP: pc_jmp=instr, pc_select=101, reg_we=0, go to EXEC. Target bits above 15 are ignored.
REQ-024 In OPND with kind=LDS or STS: latch mem_addr=instr, pc_select=001, go to MEM.
REQ-025 In MEM: mem_req=1, mem_we=1 for STS or 0 for LDS, pc_select=001, reg_we=0 while mem_ack=0.
REQ-026 In MEM with mem_ack=1: mem_req=1 for that cycle, pc_select=010, reg_we=1 only for LDS, go to EXEC.
REQ-027 In HALT: pc_select=001, reg_we=0, mem_req=0; return to EXEC in the cycle after stall_req is sampled low.
REQ-028 SHALL ignore mem_ack outside MEM.
REQ-029 SHALL ignore stall_req in OPND and MEM; a request asserted there is honoured on first EXEC cycle if still high.
REQ-030 mem_addr and mem_rd SHALL hold their last latched values outside MEM.

Reset
REQ-031 RST=1 at an edge SHALL force state=RESET, mem_addr=0, mem_rd=0, kind=none, mem_err=0, timeout counter=0. Reset value of outputs: pc_select=000, pc_jmp=0, reg_we=0, mem_req=0, mem_we=0, busy=1.
REQ-032 RST asserted during MEM or OPND SHALL abandon the transfer: mem_req is low from the first cycle after the reset edge, with no register write.

Configuration
REQ-033 Macro AVR_SEQ_MEM_TIMEOUT_EN defined: an 8-bit counter clears on MEM entry and increments each MEM cycle without ack. When it reaches 255 with no ack: set mem_err=1 (sticky until RST), reg_we=0, pc_select=010, go to EXEC.
REQ-034 Macro undefined: no counter, MEM waits indefinitely, mem_err is tied to 0.

Verification
REQ-035 RST high 2 cycles, then low -> pc_select 000 during reset and the first RESET cycle, then EXEC with busy=0.
REQ-036 instr=0xCFFF in EXEC -> pc_select=100, pc_jmp=0xFFFF, reg_we=0.
REQ-037 instr=0x940C, then 0x1234 -> cycle 1: pc_select=010; cycle 2: pc_select=101, pc_jmp=0x1234.
REQ-038 LDS 0x9150 / 0x0200 with mem_ack after 3 cycles -> mem_rd=21, mem_addr=0x0200, mem_we=0, mem_req high 4 cycles, reg_we=1 in ack cycle only.
REQ-039 STS 0x9300 / 0x0100 with RST asserted in the second MEM cycle -> mem_req=0 after the reset edge, reg_we never 1.
REQ-040 With AVR_SEQ_MEM_TIMEOUT_EN defined, LDS with mem_ack held 0 -> mem_err=1 after 255 MEM cycles, then EXEC with pc_select=010.
